// File: rtl/pipe_stage2_ctrl_pkg.sv
// Shared types and constants for the stage-2 sequencer and its stage decoder.
package pipe_stage2_ctrl_pkg;

  localparam int STAGE_W = 3;

  localparam logic [STAGE_W-1:0] STG_SCALE  = 3'd1;
  localparam logic [STAGE_W-1:0] STG_ARGMAX = 3'd5;
  localparam logic [STAGE_W-1:0] STG_ASSIGN = 3'd6;
  localparam logic [STAGE_W-1:0] STG_FINISH = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/stage2_stage_decode.sv
// Priority encoder from (step, boundaries) to the next stage index.
// The highest boundary index that the step exceeds wins, so unordered tables still resolve.
module stage2_stage_decode
  import pipe_stage2_ctrl_pkg::*;
#(
  parameter int N_BND  = 7,
  parameter int STEP_W = 16
) (
  input  logic [STEP_W-1:0]            step,
  input  logic [N_BND-1:0][STEP_W-1:0] bnd,
  output logic [STAGE_W-1:0]           stage
);

  always_comb begin
    stage = '0;
    // Ascending scan with last-match-wins gives the highest-index priority.
    for (int k = 0; k < N_BND; k++) begin
      if (step > bnd[k]) stage = STAGE_W'(k + 1);
    end
  end

endmodule

// File: rtl/pipe_stage2_ctrl.sv
// Stage-2 sequencer: step/stage tracking, valid/ready stall control and
// running arg-max bookkeeping for the similarity/normalisation datapath.
module pipe_stage2_ctrl
  import pipe_stage2_ctrl_pkg::*;
#(
  parameter int N_BND     = 7,
  parameter int STEP_W    = 16,
  parameter int WIDTH     = 16,
  parameter int N_CENTERS = 4096
) (
  input  logic               CLK_i,
  input  logic               RST_ni,
  input  logic               cfg_we_i,
  input  logic [2:0]         cfg_addr_i,
  input  logic [STEP_W-1:0]  cfg_data_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [STEP_W-1:0]  step_o,
  output logic [STAGE_W-1:0] stage_o,
  output logic               mode_o,
  input  logic               cmp_gt_i,
  input  logic [WIDTH-1:0]   pos_i,
  output logic               max_upd_o,
  output logic [WIDTH-1:0]   max_id_o,
  output logic [WIDTH-1:0]   center_id_o
);

  state_t                     state;
  logic [N_BND-1:0][STEP_W-1:0] bnd;
  logic [STEP_W-1:0]          step;
  logic [STAGE_W-1:0]         stage;
  logic [STAGE_W-1:0]         stage_next;
  logic [WIDTH-1:0]           max_id;
  logic                       busy;
  logic                       done;
  logic                       out_valid;
  logic                       in_ready;
  logic                       fire;
  logic                       max_upd;

  stage2_stage_decode #(
    .N_BND  (N_BND),
    .STEP_W (STEP_W)
  ) u_decode (
    .step  (step),
    .bnd   (bnd),
    .stage (stage_next)
  );

  // The output register frees up in the same cycle downstream takes its content.
  assign in_ready = (state == RUN) & (~out_valid | out_ready_i);
  assign fire     = in_valid_i & in_ready;
  assign max_upd  = fire & (stage == STG_ARGMAX) & cmp_gt_i;

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      state     <= IDLE;
      bnd       <= '0;
      step      <= '0;
      stage     <= '0;
      max_id    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      done <= 1'b0;

      if (fire) begin
        out_valid <= 1'b1;
      end else if (out_ready_i) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cfg_we_i) begin
            for (int k = 0; k < N_BND; k++) begin
              if (cfg_addr_i == 3'(k)) bnd[k] <= cfg_data_i;
            end
          end
          if (start_i) begin
            state  <= RUN;
            busy   <= 1'b1;
            step   <= '0;
            stage  <= '0;
            max_id <= '0;
          end
        end

        RUN: begin
          if (fire) begin
            step  <= (&step) ? step : step + 1'b1;
            stage <= stage_next;
            if (max_upd) max_id <= pos_i;
            if (stage_next == STG_FINISH) state <= DRAIN;
          end
        end

        DRAIN: begin
          if (!out_valid || out_ready_i) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy;
  assign done_o      = done;
  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid;
  assign step_o      = step;
  assign stage_o     = stage;
  assign max_id_o    = max_id;
  assign max_upd_o   = max_upd;
  assign mode_o      = (stage != STG_SCALE);
  assign center_id_o = ((stage == STG_ASSIGN) && cmp_gt_i) ? max_id : WIDTH'(N_CENTERS);

endmodule

// File: tb/tb_pipe_stage2_ctrl.sv
// Directed bench for pipe_stage2_ctrl with a per-operand scoreboard of expected
// step/stage/max_id, popped when the DUT presents the corresponding result.
module tb_pipe_stage2_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        cmp_gt = 1'b0;
  logic [15:0] pos = '0;

  logic        busy_o, done_o, in_ready_o, out_valid_o, mode_o, max_upd_o;
  logic [15:0] step_o, max_id_o, center_id_o;
  logic [2:0]  stage_o;

  always #5 clk = ~clk;

  pipe_stage2_ctrl dut (
    .CLK_i       (clk),
    .RST_ni      (rst_n),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_data_i  (cfg_data),
    .start_i     (start),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready),
    .step_o      (step_o),
    .stage_o     (stage_o),
    .mode_o      (mode_o),
    .cmp_gt_i    (cmp_gt),
    .pos_i       (pos),
    .max_upd_o   (max_upd_o),
    .max_id_o    (max_id_o),
    .center_id_o (center_id_o)
  );

  typedef struct packed {
    logic [15:0] step;
    logic [2:0]  stage;
    logic [15:0] max_id;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_fire = 0;
  logic [15:0] m_bnd [7];
  logic [15:0] m_step = '0;
  logic [15:0] m_maxid = '0;
  logic [2:0]  m_stage = '0;
  logic        m_run = 1'b0;
  logic        m_idle = 1'b1;
  logic        m_ov = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference stage: scan from the top boundary down, first hit wins.
  function automatic logic [2:0] ref_stage(input logic [15:0] s);
    for (int k = 6; k >= 0; k--) begin
      if (s > m_bnd[k]) return 3'(k + 1);
    end
    return 3'd0;
  endfunction

  // One IDLE-time config/start cycle; entered and left at posedge+1.
  task automatic ctl(input logic we, input logic [2:0] a, input logic [15:0] d, input logic s);
    cfg_we = we; cfg_addr = a; cfg_data = d; start = s;
    @(posedge clk); #1;
    cfg_we = 1'b0; start = 1'b0;
    if (we && m_idle && a < 3'd7) m_bnd[a] = d;
    if (s && m_idle) begin
      m_run = 1'b1; m_idle = 1'b0; m_ov = 1'b0;
      m_step = '0; m_stage = '0; m_maxid = '0;
      n_fire = 0;
      chk("start_busy", busy_o, 1'b1);
      chk("start_step", step_o, 16'd0);
      chk("start_stage", stage_o, 3'd0);
    end
  endtask

  // One operand cycle; entered and left at posedge+1.
  task automatic cyc(input logic v, input logic r, input logic g, input logic [15:0] p);
    logic er, ef;
    exp_t e;
    in_valid = v; out_ready = r; cmp_gt = g; pos = p;
    @(negedge clk);
    er = m_run & (~m_ov | r);
    ef = er & v;
    chk("in_ready", in_ready_o, er);
    chk("max_upd", max_upd_o, ef & (m_stage == 3'd5) & g);
    chk("mode", mode_o, m_stage != 3'd1);
    chk("center_id", center_id_o, (m_stage == 3'd6 && g) ? m_maxid : 16'd4096);
    if (in_valid && in_ready_o) n_fire++;
    if (ef) begin
      if (m_stage == 3'd5 && g) m_maxid = p;
      m_stage = ref_stage(m_step);
      m_step  = (m_step == 16'hFFFF) ? m_step : m_step + 16'd1;
      e = '{step: m_step, stage: m_stage, max_id: m_maxid};
      sb.push_back(e);
      if (m_stage == 3'd7) m_run = 1'b0;
    end
    @(posedge clk); #1;
    m_ov = ef | (m_ov & ~r);
    chk("out_valid", out_valid_o, m_ov);
    if (ef) begin
      if (out_valid_o && sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_step", step_o, e.step);
        chk("sb_stage", stage_o, e.stage);
        chk("sb_max_id", max_id_o, e.max_id);
        $display("result: step=%0d stage=%0d max_id=%0d", step_o, stage_o, max_id_o);
      end
    end else begin
      chk("step_hold", step_o, m_step);
      chk("stage_hold", stage_o, m_stage);
    end
  endtask

  task automatic run_to_end();
    while (m_run) cyc(1'b1, 1'b1, 1'b0, 16'd0);
  endtask

  // DRAIN cycle, then the single DONE cycle.
  task automatic finish_pass();
    cyc(1'b0, 1'b1, 1'b0, 16'd0);
    chk("done_pulse", done_o, 1'b1);
    chk("busy_after", busy_o, 1'b0);
    @(posedge clk); #1;
    chk("done_clear", done_o, 1'b0);
    m_idle = 1'b1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_step", step_o, 16'd0);
    chk("rst_stage", stage_o, 3'd0);
    chk("rst_max_id", max_id_o, 16'd0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_in_ready", in_ready_o, 1'b0);
    chk("rst_max_upd", max_upd_o, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 7; k++) m_bnd[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pass 1: ascending boundaries, stall window, ignored start/cfg mid-run.
    ctl(1'b1, 3'd7, 16'd55, 1'b0);
    for (int k = 0; k < 6; k++) ctl(1'b1, 3'(k), 16'(2 * k), 1'b0);
    ctl(1'b1, 3'd6, 16'd12, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 16'd0);
    start = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 16'd99;
    cyc(1'b1, 1'b1, 1'b0, 16'd0);
    start = 1'b0; cfg_we = 1'b0;
    run_to_end();
    chk("pass1_fires", n_fire, 14);
    chk("pass1_stage", stage_o, 3'd7);
    finish_pass();

    // Pass 2: arg-max in stage 5, assignment in stage 6.
    ctl(1'b1, 3'd0, 16'd0, 1'b0);
    ctl(1'b1, 3'd1, 16'd0, 1'b0);
    ctl(1'b1, 3'd2, 16'd0, 1'b0);
    ctl(1'b1, 3'd3, 16'd0, 1'b0);
    ctl(1'b1, 3'd4, 16'd1, 1'b0);
    ctl(1'b1, 3'd5, 16'd4, 1'b0);
    ctl(1'b1, 3'd6, 16'd6, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 16'd0);
    chk("argmax_stage", stage_o, 3'd5);
    cyc(1'b1, 1'b1, 1'b1, 16'd10);
    cyc(1'b1, 1'b1, 1'b0, 16'd11);
    cyc(1'b1, 1'b1, 1'b1, 16'd12);
    chk("argmax_final", max_id_o, 16'd12);
    cyc(1'b1, 1'b1, 1'b1, 16'd0);
    cyc(1'b1, 1'b1, 1'b0, 16'd0);
    chk("pass2_done_run", m_run, 1'b0);
    finish_pass();

    // Pass 3: non-monotonic boundaries, highest index wins.
    ctl(1'b1, 3'd0, 16'd9, 1'b0);
    ctl(1'b1, 3'd1, 16'd3, 1'b0);
    for (int k = 2; k < 6; k++) ctl(1'b1, 3'(k), 16'd20, 1'b0);
    ctl(1'b1, 3'd6, 16'd20, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 16'd0);
    chk("nonmono_stage", stage_o, 3'd2);
    run_to_end();
    finish_pass();

    // Pass 4: async reset at step 5 aborts the pass and clears the boundaries.
    ctl(1'b0, 3'd0, 16'd0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 16'd0);
    chk("pre_reset_step", step_o, 16'd5);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_no_done", done_o, 1'b0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) m_bnd[k] = '0;
    m_run = 1'b0; m_idle = 1'b1; m_ov = 1'b0;
    m_step = '0; m_stage = '0; m_maxid = '0;
    sb.delete();

    // Pass 5: zeroed boundaries finish after two operands.
    ctl(1'b0, 3'd0, 16'd0, 1'b1);
    run_to_end();
    chk("zero_bnd_fires", n_fire, 2);
    finish_pass();

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage2_ctrl.md
Name: pipe_stage2_ctrl

Overview:
- Sequencer for the stage-2 similarity/normalisation datapath.
- Owns the step counter, the programmable stage boundaries and the stage/mode selects.
- Owns the valid/ready stall logic.
- Owns the running arg-max bookkeeping (max_id plus max-register update enable) that the datapath consumes.
- Sits between the tile scheduler (config/start/done) and the datapath (stage_o, mode_o, stall).

Parameters:
- N_BND, 7, number of stage boundaries; stages 0..N_BND, final stage = N_BND = "finished".
- STEP_W, 16, width of the step counter and boundary registers.
- WIDTH, 16, datapath word width (pos_i, max_id_o, center_id_o).
- N_CENTERS, 4096, "no centre" sentinel driven on center_id_o.

Ports:
- CLK_i  in  1  clock.
- RST_ni  in  1  reset, asynchronous, active-low.
- cfg_we_i  in  1  boundary write strobe.
- cfg_addr_i  in  3  boundary index 0..N_BND-1.
- cfg_data_i  in  STEP_W  boundary value.
- start_i  in  1  start one pass.
- busy_o  out  1  pass in progress.
- done_o  out  1  one-cycle pulse at end of pass.
- in_valid_i  in  1  upstream operand valid.
- in_ready_o  out  1  controller accepts operand (not stalled).
- out_valid_o  out  1  datapath result valid to downstream.
- out_ready_i  in  1  downstream accepts result.
- step_o  out  STEP_W  current step count.
- stage_o  out  3  current stage.
- mode_o  out  1  reconfig-tile mode select.
- cmp_gt_i  in  1  datapath compare: candidate > current max.
- pos_i  in  WIDTH  index of current candidate.
- max_upd_o  out  1  load enable for the datapath max_cos register.
- max_id_o  out  WIDTH  index of the running maximum.
- center_id_o  out  WIDTH  assigned centre id for stage 6.

Behaviour:
- Reset (async, RST_ni low) values:
  - State = IDLE; all bnd[k] = 0.
  - step_o = 0, stage_o = 0, max_id_o = 0.
  - busy_o, done_o, out_valid_o, in_ready_o, max_upd_o = 0.
  - A reset mid-pass aborts it: no done_o, config is lost.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start_i. On that edge step = 0, stage = 0, max_id = 0.
  - RUN -> DRAIN on the fire that sets stage to N_BND.
  - DRAIN -> DONE when out_valid_o = 0, or when out_valid_o & out_ready_i.
  - DONE -> IDLE unconditionally; done_o = 1 for exactly that cycle.
  - busy_o = 1 in RUN and DRAIN. start_i outside IDLE is ignored.
- Config:
  - cfg_we_i is honoured only in IDLE; writes are dropped otherwise.
  - cfg_addr_i >= N_BND is ignored.
- Handshake:
  - fire = in_valid_i & in_ready_o.
  - in_ready_o = (state == RUN) & (~out_valid_o | out_ready_i).
  - out_valid_o is set on fire and cleared on out_ready_i without a new fire. It is a one-entry output register, so latency from operand accept to out_valid_o is 1 cycle.
  - With in_ready_o low, step/stage/max_id hold (this is the stall).
- Step/stage, updated only on fire:
  - step <= step + 1, saturating at all-ones (no wrap).
  - stage <= highest k+1 such that the old step > bnd[k], else 0. Priority runs from k = N_BND-1 downward, so non-monotonic boundaries resolve to the highest index.
  - Stage therefore lags step by one accepted operand.
- mode_o = 0 iff stage_o == 1, else 1 (combinational).
- Arg-max:
  - max_upd_o = fire & (stage_o == 5) & cmp_gt_i.
  - On max_upd_o, max_id <= pos_i.
  - Ties (cmp_gt_i = 0) keep the earlier index.
- center_id_o = (stage_o == 6 & cmp_gt_i) ? max_id_o : N_CENTERS (combinational).
- Simultaneous events:
  - start_i with cfg_we_i in IDLE: the write lands and the pass starts.
  - Fire and out_ready_i together: out_valid_o stays 1.

Decomposition:
- Package pipe_stage2_ctrl_pkg holds:
  - State enum (IDLE/RUN/DRAIN/DONE).
  - STAGE_W = 3.
  - Named stage constants STG_SCALE = 1, STG_ARGMAX = 5, STG_ASSIGN = 6, STG_FINISH = 7.
- One sub-module: stage2_stage_decode. It is the combinational priority encoder from (step, bnd[]) to next stage, and can be reused by other pipe stages.

Test Plan:
- Boundaries 0,2,4,6,8,10,12, in_valid_i = 1, out_ready_i = 1:
  - stage_o sequence 0,0,1,1,2,2,3,…, and stage_o = 7 after the 14th fire.
  - done_o pulses 2 cycles later; busy_o is low afterwards.
- Same config, out_ready_i held low for 5 cycles mid-RUN:
  - in_ready_o = 0 for those cycles; step_o and stage_o are frozen.
  - No operand is lost; the total fire count is unchanged.
- Stage 5 with pos_i = 10,11,12 and cmp_gt_i = 1,0,1:
  - max_upd_o pulses on the 1st and 3rd fire; max_id_o ends at 12.
  - In stage 6 with cmp_gt_i = 1, center_id_o = 12; with cmp_gt_i = 0, center_id_o = 4096.
- cfg_we_i to bnd[3] = 99 during RUN: ignored, and a readback-by-behaviour shows the old value. cfg_addr_i = 7: ignored.
- RST_ni asserted low at step 5 of a pass: all outputs at reset values asynchronously, no done_o pulse, and boundaries read as 0 on the next pass.
- Boundaries 9,3,…: step 5 gives stage 2, not 1 (highest-index priority). start_i during RUN: no restart, step continues.
